bcd_countdown_ctrl: RTL and testbench
=====================================

BCD_COUNTDOWN_CTRL -- requirements
Module: bcd_countdown_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4: clk cycles per count step; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled only at the posedge of clk.
REQ-004 load  input  1  pulse; captures preset into the count register.
REQ-005 preset  input  8  BCD preset: tens in [7:4], ones in [3:0].
REQ-006 start  input  1  pulse; starts from ARMED, or resumes from PAUSED.
REQ-007 pause  input  1  pulse; suspends counting in RUN.
REQ-008 clear  input  1  pulse; abandons the operation and returns to IDLE.
REQ-009 q  output  8  current BCD count: tens in [7:4], ones in [3:0]; registered.
REQ-010 busy  output  1  high in RUN and PAUSED.
REQ-011 done  output  1  one-cycle pulse when the count expires.
REQ-012 expired  output  1  level; high in EXPIRED.
REQ-013 st  output  3  state code: IDLE=0, ARMED=1, RUN=2, PAUSED=3, EXPIRED=4.

Function
REQ-014 The FSM shall have exactly five states: IDLE, ARMED, RUN, PAUSED, EXPIRED; all outputs are registered or decoded from registered state.
REQ-015 Input priority per cycle shall be: rst > clear > load > start > pause; lower-priority inputs in the same cycle are ignored.
REQ-016 clear in any state shall give, next cycle: IDLE, q=8'h00, prescaler=0, done=0.
REQ-017 load in any state shall give, next cycle: ARMED, q=sanitised preset, prescaler=0; a load during RUN or PAUSED aborts that operation without a done pulse.
REQ-018 Sanitise each preset digit individually: a digit above 9 becomes 9 (e.g. 8'hA3 -> 8'h93, 8'h4F -> 8'h49).
REQ-019 start in ARMED with q != 00 shall enter RUN next cycle with prescaler=0.
REQ-020 start in ARMED with q == 00 shall enter EXPIRED next cycle and pulse done in that cycle.
REQ-021 start in IDLE, RUN or EXPIRED shall be ignored; pause outside RUN shall be ignored.
REQ-022 In RUN, the prescaler shall count 0..TICK_DIV-1 and then wrap; the wrap cycle is a tick.
REQ-023 On a tick the count shall decrement by one in BCD.
REQ-024 BCD decrement, ones != 0: ones -= 1.
REQ-025 BCD decrement, ones == 0: ones becomes 9 and tens -= 1.
REQ-026 First step from ARMED: q changes exactly TICK_DIV cycles after the RUN-entry cycle; later steps are spaced exactly TICK_DIV cycles apart.
REQ-027 When a tick takes q from 01 to 00: in the same edge, q=00, state=EXPIRED, done=1 for exactly that one cycle.
REQ-028 q shall never wrap below 00.
REQ-029 pause in RUN shall enter PAUSED next cycle, freezing q and the prescaler.
REQ-030 A tick coincident with pause shall still be applied before freezing.
REQ-031 If that coincident tick reaches 00, EXPIRED wins over PAUSED.
REQ-032 start in PAUSED shall return to RUN, continuing the prescaler from its frozen value, with no lost or extra tick.
REQ-033 EXPIRED shall hold q=00 and expired=1 until load or clear.
REQ-034 q shall never hold a non-BCD digit (A-F) in any state.

Reset
REQ-035 On rst: state=IDLE, q=8'h00, prescaler=0, busy=0, done=0, expired=0, st=0.
REQ-036 rst asserted mid-RUN or mid-PAUSED shall abort with no done pulse.
REQ-037 Outputs shall follow the reset values from the first posedge after rst is sampled high, with no dependence on prior state.

Verification (TICK_DIV=4)
REQ-038 load 8'h12, start, run freely -> q steps 12,11,10,09,...,01,00 every 4 cycles; done pulses once, in the cycle q becomes 00; expired stays high.
REQ-039 load 8'h03, start, pause after 6 RUN cycles, hold 10 cycles, start -> q=02 frozen during PAUSED; total RUN cycles to 00 = 12.
REQ-040 load 8'hFA -> q=8'h99; load 8'h00 then start -> EXPIRED and done=1 one cycle after start.
REQ-041 load, start and clear asserted together in RUN -> IDLE, q=00, no done; start in IDLE afterwards -> no effect.
REQ-042 rst asserted at q=05 in RUN -> next cycle IDLE, q=00, busy=0, done never asserted.
REQ-043 load 8'h10, start; assert pause on the tick cycle -> q=09 and state=PAUSED; load 8'h01, start, pause on the tick cycle -> state=EXPIRED with one done pulse.

Source files
------------

// File: rtl/bcd_countdown_ctrl.sv
// bcd_countdown_ctrl: two-digit BCD countdown timer with arm/run/pause/expire control
module bcd_countdown_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] preset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] q,
    output logic       busy,
    output logic       done,
    output logic       expired,
    output logic [2:0] st
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] pre;
    logic       tick;

    function automatic logic [3:0] sat(input logic [3:0] d);
        return d > 4'd9 ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] v);
        return v[3:0] != 4'd0 ? {v[7:4], v[3:0] - 4'd1} : {v[7:4] - 4'd1, 4'd9};
    endfunction

    assign tick    = pre == 8'(TICK_DIV - 1);
    assign busy    = state == RUN || state == PAUSED;
    assign expired = state == EXPIRED;
    assign st      = state;

    // control FSM: priority rst > clear > load > start > pause; done is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= 8'h00;
            pre   <= 8'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state <= IDLE;
                q     <= 8'h00;
                pre   <= 8'd0;
            end else if (load) begin
                state <= ARMED;
                q     <= {sat(preset[7:4]), sat(preset[3:0])};
                pre   <= 8'd0;
            end else if (start && state == ARMED) begin
                state <= q == 8'h00 ? EXPIRED : RUN;
                done  <= q == 8'h00;
                pre   <= 8'd0;
            end else if (start && state == PAUSED) begin
                state <= RUN;
            end else if (state == RUN) begin
                pre <= tick ? 8'd0 : pre + 8'd1;
                if (tick) q <= dec(q);
                if (tick && q == 8'h01) begin
                    state <= EXPIRED;
                    done  <= 1'b1;
                end else if (pause) begin
                    state <= PAUSED;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// tb_bcd_countdown_ctrl: directed and randomized checks against a decimal-arithmetic reference model
module tb_bcd_countdown_ctrl;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] preset = 8'h00;
    logic [7:0] q;
    logic       busy, done, expired;
    logic [2:0] st;

    int npass = 0;
    int ntot  = 0;
    int mst   = 0;
    int mcnt  = 0;
    int mpre  = 0;
    bit mdone = 1'b0;

    bcd_countdown_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load(load), .preset(preset), .start(start),
        .pause(pause), .clear(clear), .q(q), .busy(busy), .done(done),
        .expired(expired), .st(st)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mq();
        return {4'(mcnt / 10), 4'(mcnt % 10)};
    endfunction

    function automatic int clip(input int d);
        return d > 9 ? 9 : d;
    endfunction

    // reference: count kept as a decimal integer, time kept as cycles within a step
    task automatic model_step(input bit r, l, s, pa, c, input logic [7:0] p);
        mdone = 1'b0;
        if (r || c) begin
            mst = 0; mcnt = 0; mpre = 0;
        end else if (l) begin
            mst = 1; mpre = 0;
            mcnt = 10 * clip(int'(p[7:4])) + clip(int'(p[3:0]));
        end else if (s && mst == 1) begin
            mpre = 0;
            if (mcnt == 0) begin mst = 4; mdone = 1'b1; end
            else mst = 2;
        end else if (s && mst == 3) begin
            mst = 2;
        end else if (mst == 2) begin
            mpre = mpre + 1;
            if (mpre == TD) begin
                mpre = 0;
                mcnt = mcnt - 1;
            end
            if (mpre == 0 && mcnt == 0) begin mst = 4; mdone = 1'b1; end
            else if (pa) mst = 3;
        end
    endtask

    task automatic cyc(input bit r, l, s, pa, c, input logic [7:0] p);
        rst = r; load = l; start = s; pause = pa; clear = c; preset = p;
        @(posedge clk);
        model_step(r, l, s, pa, c, p);
        #1;
        rst = 0; load = 0; start = 0; pause = 0; clear = 0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 8'h00);
        ntot++;
        if (q !== 8'h00 || st !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || expired !== 1'b0)
            $display("FAIL reset q=%h st=%0d busy=%b done=%b exp=%b required 00/0/0/0/0", q, st, busy, done, expired);
        else npass++;
    endtask

    task automatic test_free_run();
        int nd;
        nd = 0;
        cyc(0, 1, 0, 0, 0, 8'h12);
        ntot++;
        if (q !== 8'h12 || st !== 3'd1) $display("FAIL free_load q=%h st=%0d required 12/1", q, st);
        else npass++;
        cyc(0, 0, 1, 0, 0, 8'h00);
        ntot++;
        if (st !== 3'd2 || busy !== 1'b1) $display("FAIL free_start st=%0d busy=%b required 2/1", st, busy);
        else npass++;
        for (int i = 0; i < 56; i++) begin
            cyc(0, 0, 0, 0, 0, 8'h00);
            nd += int'(done);
            ntot++;
            if (q !== mq() || st !== 3'(mst) || done !== mdone)
                $display("FAIL free_run cyc%0d q=%h st=%0d done=%b required %h/%0d/%b", i, q, st, done, mq(), mst, mdone);
            else npass++;
        end
        ntot++;
        if (nd != 1 || q !== 8'h00 || expired !== 1'b1)
            $display("FAIL free_end done_count=%0d q=%h exp=%b required 1/00/1", nd, q, expired);
        else npass++;
    endtask

    task automatic test_pause_resume();
        int runc;
        runc = 0;
        cyc(0, 1, 0, 0, 0, 8'h03);
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            runc += int'(st == 3'd2);
            cyc(0, 0, 0, i == 5, 0, 8'h00);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 8'h00);
            ntot++;
            if (q !== 8'h02 || st !== 3'd3 || busy !== 1'b1)
                $display("FAIL paused_hold cyc%0d q=%h st=%0d busy=%b required 02/3/1", i, q, st, busy);
            else npass++;
        end
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 20 && st == 3'd2; i++) begin
            runc++;
            cyc(0, 0, 0, 0, 0, 8'h00);
            ntot++;
            if (q !== mq() || st !== 3'(mst) || done !== mdone)
                $display("FAIL resume cyc%0d q=%h st=%0d done=%b required %h/%0d/%b", i, q, st, done, mq(), mst, mdone);
            else npass++;
        end
        ntot++;
        if (runc != 12 || st !== 3'd4 || q !== 8'h00)
            $display("FAIL pause_total run_cycles=%0d st=%0d q=%h required 12/4/00", runc, st, q);
        else npass++;
    endtask

    task automatic test_sanitise();
        logic [7:0] pin [3]  = '{8'hFA, 8'hA3, 8'h4F};
        logic [7:0] pexp [3] = '{8'h99, 8'h93, 8'h49};
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, pin[i]);
            ntot++;
            if (q !== pexp[i] || st !== 3'd1) $display("FAIL sanitise %h q=%h st=%0d required %h/1", pin[i], q, st, pexp[i]);
            else npass++;
        end
        cyc(0, 1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'h00);
        ntot++;
        if (st !== 3'd4 || done !== 1'b1 || expired !== 1'b1)
            $display("FAIL zero_start st=%0d done=%b exp=%b required 4/1/1", st, done, expired);
        else npass++;
        cyc(0, 0, 0, 0, 0, 8'h00);
        ntot++;
        if (st !== 3'd4 || done !== 1'b0 || expired !== 1'b1 || q !== 8'h00)
            $display("FAIL zero_hold st=%0d done=%b exp=%b q=%h required 4/0/1/00", st, done, expired, q);
        else npass++;
    endtask

    task automatic test_clear_priority();
        cyc(0, 1, 0, 0, 0, 8'h12);
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 1, 8'h55);
        ntot++;
        if (st !== 3'd0 || q !== 8'h00 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL clear_prio st=%0d q=%h done=%b busy=%b required 0/00/0/0", st, q, done, busy);
        else npass++;
        cyc(0, 0, 1, 0, 0, 8'h00);
        ntot++;
        if (st !== 3'd0 || q !== 8'h00) $display("FAIL idle_start st=%0d q=%h required 0/00", st, q);
        else npass++;
    endtask

    task automatic test_rst_midrun();
        int nd;
        nd = 0;
        cyc(0, 1, 0, 0, 0, 8'h08);
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 40 && q !== 8'h05; i++) begin
            cyc(0, 0, 0, 0, 0, 8'h00);
            nd += int'(done);
        end
        ntot++;
        if (q !== 8'h05 || st !== 3'd2) $display("FAIL rst_reach q=%h st=%0d required 05/2", q, st);
        else npass++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        nd += int'(done);
        ntot++;
        if (st !== 3'd0 || q !== 8'h00 || busy !== 1'b0 || nd != 0)
            $display("FAIL rst_midrun st=%0d q=%h busy=%b done_count=%0d required 0/00/0/0", st, q, busy, nd);
        else npass++;
    endtask

    task automatic test_pause_on_tick();
        cyc(0, 1, 0, 0, 0, 8'h10);
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < TD - 1; i++) cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        ntot++;
        if (q !== 8'h09 || st !== 3'd3) $display("FAIL pause_tick q=%h st=%0d required 09/3", q, st);
        else npass++;
        cyc(0, 1, 0, 0, 0, 8'h01);
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < TD - 1; i++) cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        ntot++;
        if (q !== 8'h00 || st !== 3'd4 || done !== 1'b1)
            $display("FAIL pause_expire q=%h st=%0d done=%b required 00/4/1", q, st, done);
        else npass++;
        cyc(0, 0, 0, 0, 0, 8'h00);
        ntot++;
        if (done !== 1'b0 || st !== 3'd4) $display("FAIL pause_expire_pulse done=%b st=%0d required 0/4", done, st);
        else npass++;
    endtask

    task automatic test_random();
        bit r, l, s, pa, c;
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 99) == 0;
            c  = $urandom_range(0, 59) == 0;
            l  = $urandom_range(0, 29) == 0;
            s  = $urandom_range(0, 5) == 0;
            pa = $urandom_range(0, 9) == 0;
            cyc(r, l, s, pa, c, 8'($urandom));
            ntot++;
            if (q !== mq() || st !== 3'(mst) || done !== mdone || busy !== (mst == 2 || mst == 3) || expired !== (mst == 4))
                $display("FAIL random cyc%0d q=%h st=%0d done=%b busy=%b exp=%b required %h/%0d/%b", i, q, st, done, busy, expired, mq(), mst, mdone);
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_pause_resume();
        test_sanitise();
        test_clear_priority();
        test_rst_midrun();
        test_pause_on_tick();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
